// File: rtl/altera_up_slow_clock_generator.sv
// altera_up_slow_clock_generator: power-of-two clock divider with edge and mid-phase strobes
module altera_up_slow_clock_generator #(
  parameter int CB  = 10,
  parameter int INC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_clk,
  output logic new_clk,
  output logic rising_edge,
  output logic falling_edge,
  output logic middle_of_high_level,
  output logic middle_of_low_level
);
  logic [CB-1:0] c;
  logic mid;
  always_ff @(posedge clk) begin
    if (reset) begin
      c            <= '0;
      new_clk      <= 1'b0;
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
    end else begin
      if (enable_clk) c <= c + CB'(INC);
      new_clk      <= c[CB-1];
      rising_edge  <= c[CB-1] & ~new_clk;
      falling_edge <= ~c[CB-1] & new_clk;
    end
  end
  assign mid                  = ~c[CB-2] & (&c[CB-3:0]);
  assign middle_of_high_level = new_clk & mid;
  assign middle_of_low_level  = ~new_clk & mid;
endmodule

// File: tb/tb_altera_up_slow_clock_generator.sv
// tb_altera_up_slow_clock_generator: randomized checks against a cycle-count reference model
module tb_altera_up_slow_clock_generator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable_clk = 1'b0;
  logic new_clk, rising_edge, falling_edge, middle_of_high_level, middle_of_low_level;
  altera_up_slow_clock_generator #(.CB(10), .INC(1)) dut (
    .clk(clk),
    .reset(reset),
    .enable_clk(enable_clk),
    .new_clk(new_clk),
    .rising_edge(rising_edge),
    .falling_edge(falling_edge),
    .middle_of_high_level(middle_of_high_level),
    .middle_of_low_level(middle_of_low_level)
  );
  always #5 clk = ~clk;
  int m_cnt;
  bit m_clk, m_rise, m_fall;
  int n_chk, n_pass;
  int cyc, last_rise, per_exp, en_since;
  bit rise_seen, lat_chk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic step(input bit r, input bit e);
    bit hi;
    reset = r;
    enable_clk = e;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_cnt = 0;
      m_clk = 0;
      m_rise = 0;
      m_fall = 0;
      en_since = 0;
      rise_seen = 0;
      last_rise = -1;
    end else begin
      hi = m_cnt >= 512;
      m_rise = hi && !m_clk;
      m_fall = !hi && m_clk;
      m_clk = hi;
      if (e) begin
        m_cnt = (m_cnt + 1) % 1024;
        en_since++;
      end
    end
    @(negedge clk);
    chk("new_clk", new_clk, m_clk);
    chk("rising_edge", rising_edge, m_rise);
    chk("falling_edge", falling_edge, m_fall);
    chk("mid_high", middle_of_high_level, m_clk && (m_cnt % 512 == 255));
    chk("mid_low", middle_of_low_level, !m_clk && (m_cnt % 512 == 255));
    if (!r && rising_edge === 1'b1) begin
      if (lat_chk && !rise_seen) chk("rise_latency", en_since, 513);
      if (per_exp > 0 && last_rise >= 0) chk("period", cyc - last_rise, per_exp);
      rise_seen = 1;
      last_rise = cyc;
    end
  endtask
  initial begin
    lat_chk = 1;
    per_exp = 1024;
    repeat (3) step(1, 1);
    repeat (3000) step(0, 1);
    per_exp = 0;
    lat_chk = 0;
    for (int i = 0; i < 2048 && m_cnt != 767; i++) step(0, 1);
    chk("mid_high_at_767", middle_of_high_level, 1);
    repeat (20) step(0, 0);
    chk("mid_high_held", middle_of_high_level, 1);
    last_rise = -1;
    per_exp = 2048;
    for (int i = 0; i < 6000; i++) step(0, i[0]);
    per_exp = 0;
    for (int i = 0; i < 4096 && !(m_cnt == 800 && m_clk); i++) step(0, 1);
    chk("new_clk_before_reset", new_clk, 1);
    step(1, 1);
    chk("no_fall_on_reset", falling_edge, 0);
    lat_chk = 1;
    repeat (600) step(0, 1);
    lat_chk = 0;
    repeat (4000) step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
